uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter peripheral, a sibling of the LED8 output peripheral.
- Consumes the same one-cycle `begin_flag`/`in_data` write strobe that the top level decodes from CPU stores. The new store address is 0x0000_03f4.
- Exposes a status word that the top level muxes onto the dmem read path at 0x0000_03f0.
- Buffers bytes in a small FIFO and serialises them 8N1, LSB first, on `tx`.

---
 rtl/uart_tx_mmio.sv | 152 +++++++++++++++
 tb/tb_uart_tx_mmio.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores push bytes into a small FIFO,
// a bit-timed shifter drains it onto tx, and a status word reports progress.
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] in_data,
  input  logic        begin_flag,
  output logic [31:0] state_reg,
  output logic        tx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_COUNT  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST     = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t       state, state_next;
  logic [TW-1:0]   timer, timer_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      shift, shift_next;
  logic            tx_next;
  logic            pop;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            overflow;

  logic            ctrl_write, push_req, push_ok;
  logic            unused_data_bits;

  assign ctrl_write       = begin_flag & in_data[31];
  assign push_req         = begin_flag & ~in_data[31];
  assign push_ok          = push_req & ((count != DEPTH_COUNT) | pop);
  assign unused_data_bits = ^in_data[30:8];

  // Shifter next-state: pops happen only when a frame can start immediately
  always_comb begin
    state_next   = state;
    timer_next   = (timer != '0) ? timer - TW'(1) : timer;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    tx_next      = tx;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        timer_next = timer;
        if (count != '0) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          tx_next    = 1'b0;
          timer_next = TIMER_RELOAD;
          state_next = START;
        end else begin
          tx_next = 1'b1;
        end
      end
      START: begin
        if (timer == '0) begin
          tx_next      = shift[0];
          timer_next   = TIMER_RELOAD;
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (timer == '0) begin
          timer_next = TIMER_RELOAD;
          if (bit_idx != 3'd7) begin
            shift_next   = {1'b0, shift[7:1]};
            tx_next      = shift[1];
            bit_idx_next = bit_idx + 3'd1;
          end else begin
            tx_next    = 1'b1;
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (timer == '0) begin
          if (count != '0) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            tx_next    = 1'b0;
            timer_next = TIMER_RELOAD;
            state_next = START;
          end else begin
            tx_next    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      tx      <= tx_next;
    end
  end

  // A full FIFO still accepts a byte when the head leaves on the same edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      if (push_ok)
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (push_ok && !pop)
        count <= count + CW'(1);
      else if (!push_ok && pop)
        count <= count - CW'(1);
      if (ctrl_write)
        overflow <= 1'b0;
      else if (push_req && !push_ok)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok)
      mem[wr_ptr] <= in_data[7:0];
  end

  assign state_reg = {16'h0000, 8'(count), 4'h0, tx, overflow,
                      (count == DEPTH_COUNT), (state != IDLE) | (count != '0)};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomised bench for uart_tx_mmio: a frame-timing reference model predicts
// the status word and tx line every cycle.
module tb_uart_tx_mmio;

  localparam int C = 4;
  localparam int D = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        begin_flag = 1'b0;
  logic [31:0] state_reg;
  logic        tx;

  int total = 0;
  int bad = 0;
  int edge_n = 0;

  bit [7:0] model_q[$];
  bit       model_active = 1'b0;
  int       model_start = 0;
  bit [7:0] model_cur = 8'h00;
  bit       model_ovf = 1'b0;

  uart_tx_mmio #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .in_data(in_data),
    .begin_flag(begin_flag),
    .state_reg(state_reg),
    .tx(tx)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h (edge %0d)", tag, observed, expected, edge_n);
    end
  endtask

  // Line value from frame position: start bit, 8 data bits LSB first, stop bit
  function automatic logic model_tx();
    int off, b;
    if (!model_active) return 1'b1;
    off = edge_n - model_start;
    b = off / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return model_cur[b-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    logic busy, full;
    busy = model_active || (model_q.size() != 0);
    full = (model_q.size() == D);
    return {16'h0000, 8'(model_q.size()), 4'h0, model_tx(), model_ovf, full, busy};
  endfunction

  task automatic model_reset();
    model_q.delete();
    model_active = 1'b0;
    model_ovf = 1'b0;
  endtask

  // A byte starts when the line is free: immediately if idle, else when the
  // previous frame's 10 bit times end
  task automatic model_edge(input logic bf, input logic [31:0] d);
    bit frame_end, pop;
    frame_end = model_active && (edge_n == model_start + 10 * C);
    pop = (model_q.size() > 0) && (!model_active || frame_end);
    if (frame_end && !pop) model_active = 1'b0;
    if (pop) begin
      model_cur = model_q.pop_front();
      model_start = edge_n;
      model_active = 1'b1;
    end
    if (bf) begin
      if (d[31]) model_ovf = 1'b0;
      else if (model_q.size() < D) model_q.push_back(d[7:0]);
      else model_ovf = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic bf, input logic [31:0] d);
    begin_flag = bf;
    in_data = d;
    @(posedge clock);
    edge_n++;
    model_edge(bf, d);
    @(negedge clock);
    checkOutput("status", state_reg, model_status());
    checkOutput("tx", {31'b0, tx}, {31'b0, model_tx()});
    begin_flag = 1'b0;
    in_data = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, $urandom);
  endtask

  task automatic wait_not_busy(input string tag);
    int guard;
    guard = 0;
    while (state_reg[0] && guard < 1000) begin
      applyStimulus(1'b0, $urandom);
      guard++;
    end
    checkOutput({tag, "_timeout"}, {31'b0, (guard < 1000)}, 32'd1);
    idle_cycles(3);
  endtask

  initial begin
    // Reset and idle
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_status", state_reg, 32'h0000_0008);
    checkOutput("reset_tx", {31'b0, tx}, 32'd1);
    model_reset();
    reset_n = 1'b1;
    idle_cycles(20);

    // Single byte
    applyStimulus(1'b1, 32'h0000_00A5);
    wait_not_busy("single");
    checkOutput("single_done", state_reg, 32'h0000_0008);

    // Back-to-back frames
    applyStimulus(1'b1, 32'h0000_0055);
    applyStimulus(1'b1, 32'h0000_000F);
    wait_not_busy("b2b");

    // Full and overflow
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 32'(i));
    checkOutput("ovf_set", {31'b0, state_reg[2]}, 32'd1);
    checkOutput("full_set", {31'b0, state_reg[1]}, 32'd1);
    applyStimulus(1'b1, 32'h8000_0000);
    checkOutput("ovf_clear", {31'b0, state_reg[2]}, 32'd0);
    wait_not_busy("ovf");

    // Pointer wrap-around across bursts
    for (int burst = 0; burst < 4; burst++) begin
      for (int i = 0; i < 5; i++)
        applyStimulus(1'b1, {1'b0, 31'($urandom)});
      wait_not_busy("wrap");
    end

    // Reset in the middle of a frame
    applyStimulus(1'b1, 32'h0000_003C);
    applyStimulus(1'b1, 32'h0000_00C3);
    applyStimulus(1'b1, 32'h0000_0077);
    idle_cycles(3 * C + 1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_tx", {31'b0, tx}, 32'd1);
    checkOutput("midrst_status", state_reg, 32'h0000_0008);
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle_cycles(60);

    // Random traffic with control writes and junk upper bits
    for (int i = 0; i < 600; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 7) != 0) d[31] = 1'b0;
      applyStimulus($urandom_range(0, 11) == 0, d);
    end
    wait_not_busy("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
